// File: rtl/mmm_nlp_pkg.sv
// Shared definitions for the tiled multi-cycle multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   state_e  - controller states (IDLE=0, MUL=1, DONE=2), 2-bit encoding
//   cdiv     - ceiling divide, used to derive the tile counts
//   bits_for - width of a counter holding 0..n-1 (never less than 1)
package mmm_nlp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cdiv(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // A zero-width counter is not legal, so degenerate single-value ranges still get one bit.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmm_nlp_pp_mul.sv
// Unsigned OAW x OBW partial-product multiplier, one tile pair per call.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller sequences the operands.
//
// Ports:
//   a_i - A tile, OAW bits, unsigned
//   b_i - B tile, OBW bits, unsigned
//   p_o - full-width product, OAW+OBW bits
module mmm_nlp_pp_mul #(
    parameter int OAW = 24,
    parameter int OBW = 16
) (
    input  logic [OAW-1:0]     a_i,
    input  logic [OBW-1:0]     b_i,
    output logic [OAW+OBW-1:0] p_o
);

    // Both operands widened to the product width so no bits of the product are lost.
    assign p_o = {{OBW{1'b0}}, a_i} * {{OAW{1'b0}}, b_i};

endmodule

// File: rtl/mmm_nlp_tile_mul.sv
// Wide unsigned multiply / multiply-accumulate built from one small tile multiplier.
// Latency: result valid NA*NB cycles after the accepting edge; issue interval NA*NB+2.
// Backpressure: o_rdy only in IDLE; result held in DONE until i_rdy, i_vld ignored meanwhile.
//
// Ports:
//   i_clk, i_rstn  - clock, asynchronous active-low reset
//   i_vld / o_rdy  - operand request handshake (i_a, i_b, i_acc)
//   i_acc          - 1: add the product onto the previous result, 0: plain multiply
//   o_vld / i_rdy  - result handshake (o_res, ODW bits, modulo 2^ODW)
module mmm_nlp_tile_mul
    import mmm_nlp_pkg::*;
#(
    parameter int IDW = 90,
    parameter int OAW = 24,
    parameter int OBW = 16,
    parameter int ODW = 181
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_vld,
    output logic           o_rdy,
    input  logic [IDW-1:0] i_a,
    input  logic [IDW-1:0] i_b,
    input  logic           i_acc,
    output logic           o_vld,
    input  logic           i_rdy,
    output logic [ODW-1:0] o_res
);

    localparam int NA   = cdiv(IDW, OAW);
    localparam int NB   = cdiv(IDW, OBW);
    localparam int NT   = NA * NB;
    localparam int CNTW = bits_for(NT);
    localparam int RW   = bits_for(NA);
    localparam int CW   = bits_for(NB);
    localparam int PW   = OAW + OBW;
    // Largest tile offset is (NA-1)*OAW + (NB-1)*OBW.
    localparam int SHW  = bits_for((NA - 1) * OAW + (NB - 1) * OBW + 1);

    if (ODW < 2 * IDW) begin : g_bad_odw
        $error("mmm_nlp_tile_mul: ODW must be at least 2*IDW");
    end

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    // Row/column tile indices track cnt/NB and cnt%NB without a divider.
    logic [RW-1:0]    ti_q, ti_d;
    logic [CW-1:0]    tj_q, tj_d;
    logic [IDW-1:0]   a_q, a_d;
    logic [IDW-1:0]   b_q, b_d;
    logic             accf_q, accf_d;
    logic [ODW-1:0]   acc_q, acc_d;

    // Operands zero-extended to whole tiles so the top tiles read zeros beyond IDW.
    logic [NA*OAW-1:0] a_ext;
    logic [NB*OBW-1:0] b_ext;
    logic [OAW-1:0]    a_tile;
    logic [OBW-1:0]    b_tile;
    logic [PW-1:0]     pp;
    logic [SHW-1:0]    shamt;
    logic [ODW-1:0]    pp_term;
    logic [ODW-1:0]    acc_base;

    assign a_ext = (NA * OAW)'(a_q);
    assign b_ext = (NB * OBW)'(b_q);

    always_comb begin
        a_tile = '0;
        for (int k = 0; k < NA; k++) begin
            if (ti_q == RW'(k)) begin
                a_tile = a_ext[k*OAW +: OAW];
            end
        end
    end

    always_comb begin
        b_tile = '0;
        for (int k = 0; k < NB; k++) begin
            if (tj_q == CW'(k)) begin
                b_tile = b_ext[k*OBW +: OBW];
            end
        end
    end

    mmm_nlp_pp_mul #(
        .OAW (OAW),
        .OBW (OBW)
    ) u_pp_mul (
        .a_i (a_tile),
        .b_i (b_tile),
        .p_o (pp)
    );

    assign shamt   = SHW'(ti_q) * SHW'(OAW) + SHW'(tj_q) * SHW'(OBW);
    // Bits shifted past ODW are dropped: accumulation is modulo 2^ODW.
    assign pp_term = ODW'(pp) << shamt;

    // A plain multiply always starts its first tile from a zero base.
    assign acc_base = ((cnt_q == '0) && !accf_q) ? '0 : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ti_d    = ti_q;
        tj_d    = tj_q;
        a_d     = a_q;
        b_d     = b_q;
        accf_d  = accf_q;
        acc_d   = acc_q;

        case (state_q)
            IDLE: begin
                if (i_vld) begin
                    state_d = MUL;
                    cnt_d   = '0;
                    ti_d    = '0;
                    tj_d    = '0;
                    a_d     = i_a;
                    b_d     = i_b;
                    accf_d  = i_acc;
                    if (!i_acc) begin
                        acc_d = '0;
                    end
                end
            end

            MUL: begin
                acc_d = acc_base + pp_term;
                if (cnt_q == CNTW'(NT - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    ti_d    = '0;
                    tj_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (tj_q == CW'(NB - 1)) begin
                        tj_d = '0;
                        ti_d = ti_q + RW'(1);
                    end else begin
                        tj_d = tj_q + CW'(1);
                    end
                end
            end

            DONE: begin
                if (i_rdy) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ti_q    <= '0;
            tj_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            accf_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ti_q    <= ti_d;
            tj_q    <= tj_d;
            a_q     <= a_d;
            b_q     <= b_d;
            accf_q  <= accf_d;
            acc_q   <= acc_d;
        end
    end

    assign o_rdy = (state_q == IDLE);
    assign o_vld = (state_q == DONE);
    assign o_res = acc_q;

endmodule

// File: tb/tb_mmm_nlp_tile_mul.sv
`timescale 1ns/1ps
module tb_mmm_nlp_tile_mul;

    localparam int IDW = 90;
    localparam int OAW = 24;
    localparam int OBW = 16;
    localparam int ODW = 181;
    localparam int NT  = 24;
    localparam int NV  = 12;
    localparam int NRND = 1500;

    typedef logic [IDW-1:0] op_t;
    typedef logic [ODW-1:0] res_t;
    typedef struct { op_t a; op_t b; logic acc; res_t exp; } vec_t;
    typedef struct { res_t exp; string nm; } sb_t;

    logic i_clk  = 1'b1;
    logic i_rstn = 1'b1;
    logic i_vld  = 1'b0;
    logic o_rdy;
    op_t  i_a    = '0;
    op_t  i_b    = '0;
    logic i_acc  = 1'b0;
    logic o_vld;
    logic i_rdy  = 1'b1;
    res_t o_res;

    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    sb_t  sb[$];

    mmm_nlp_tile_mul #(
        .IDW (IDW),
        .OAW (OAW),
        .OBW (OBW),
        .ODW (ODW)
    ) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_vld  (i_vld),
        .o_rdy  (o_rdy),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_acc  (i_acc),
        .o_vld  (o_vld),
        .i_rdy  (i_rdy),
        .o_res  (o_res)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    function automatic res_t model_mul(input op_t a, input op_t b);
        logic [2*IDW-1:0] p;
        p = {{IDW{1'b0}}, a} * {{IDW{1'b0}}, b};
        return ODW'(p);
    endfunction

    function automatic op_t rnd_op();
        op_t v;
        v = op_t'({$urandom, $urandom, $urandom});
        case ($urandom_range(0, 2))
            0:       v[IDW-1:IDW-26] = '0;
            1:       v[IDW-1:IDW-26] = '1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic chk(input string nm, input res_t act, input res_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_reset(input string nm);
        chk({nm, "_vld"}, res_t'(o_vld), res_t'(0));
        chk({nm, "_rdy"}, res_t'(o_rdy), res_t'(1));
        chk({nm, "_res"}, o_res, res_t'(0));
    endtask

    // Scoreboard consumer: one result per DONE cycle that sees i_rdy high.
    always @(negedge i_clk) begin : mon
        sb_t e;
        if (i_rstn && o_vld && i_rdy) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0h want none", o_res);
            end else begin
                e = sb.pop_front();
                chk(e.nm, o_res, e.exp);
            end
        end
    end

    // Called away from the clock edge; returns #1 after the accepting edge.
    task automatic send(input op_t a, input op_t b, input logic acc, input res_t exp,
                        input string nm, input bit rnd_rdy);
        int n = 0;
        i_vld = 1'b1;
        i_a   = a;
        i_b   = b;
        i_acc = acc;
        while (!o_rdy && n < 200) begin
            @(posedge i_clk);
            #1;
            n++;
            if (rnd_rdy) i_rdy = ($urandom_range(0, 1) == 1);
        end
        if (!o_rdy) begin
            total++;
            bad++;
            $display("FAIL %s_accept_timeout: o_rdy=0 want 1", nm);
            i_vld = 1'b0;
        end else begin
            sb.push_back('{exp, nm});
            @(posedge i_clk);
            #1;
            acc_cyc = cyc;
            i_vld   = 1'b0;
        end
    endtask

    task automatic wait_done(input string nm, input bit rnd_rdy);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge i_clk);
            #1;
            n++;
            i_rdy = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_result_timeout: pending=%0d want 0", nm, sb.size());
            sb.delete();
        end
        i_rdy = 1'b1;
    endtask

    initial begin
        vec_t tbl[NV];
        res_t run;
        op_t  mx;
        op_t  one;
        op_t  a1;
        op_t  b1;
        int   n;
        int   seen;
        int   bad_before;

        mx  = '1;
        one = op_t'(1);

        tbl[0]  = '{a: '0,                                 b: '0,                                 acc: 1'b0, exp: '0};
        tbl[1]  = '{a: one,                                b: one,                                acc: 1'b0, exp: '0};
        tbl[2]  = '{a: mx,                                 b: one,                                acc: 1'b0, exp: '0};
        tbl[3]  = '{a: one,                                b: mx,                                 acc: 1'b0, exp: '0};
        tbl[4]  = '{a: one << 89,                          b: one << 89,                          acc: 1'b0, exp: '0};
        tbl[5]  = '{a: op_t'({3{32'hAAAA_AAAA}}),          b: op_t'({3{32'h5555_5555}}),          acc: 1'b0, exp: '0};
        tbl[6]  = '{a: mx,                                 b: mx,                                 acc: 1'b1, exp: '0};
        tbl[7]  = '{a: mx,                                 b: mx,                                 acc: 1'b1, exp: '0};
        tbl[8]  = '{a: mx,                                 b: mx,                                 acc: 1'b1, exp: '0};
        tbl[9]  = '{a: (one << 24) - one,                  b: (one << 16) - one,                  acc: 1'b0, exp: '0};
        tbl[10] = '{a: one << 24,                          b: one << 16,                          acc: 1'b0, exp: '0};
        tbl[11] = '{a: rnd_op(),                           b: rnd_op(),                           acc: 1'b1, exp: '0};
        run = '0;
        for (int k = 0; k < NV; k++) begin
            run = tbl[k].acc ? (run + model_mul(tbl[k].a, tbl[k].b)) : model_mul(tbl[k].a, tbl[k].b);
            tbl[k].exp = run;
        end

        // Reset held low for two rising edges (20 ns and 30 ns).
        #15;
        i_rstn = 1'b0;
        #1;
        chk_idle_reset("rst_during_a");
        #18;
        chk_idle_reset("rst_during_b");
        #1;
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
        chk_idle_reset("rst_after");

        // Full scale: (2^90-1)^2 = 2^180 - 2^91 + 1, valid exactly 24 edges after accept.
        send(mx, mx, 1'b0, (res_t'(1) << 180) - (res_t'(1) << 91) + res_t'(1), "full_scale", 1'b0);
        n = 0;
        while (!o_vld && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("full_latency", res_t'(cyc - acc_cyc), res_t'(NT));
        wait_done("full_scale", 1'b0);

        for (int k = 0; k < NV; k++) begin
            send(tbl[k].a, tbl[k].b, tbl[k].acc, tbl[k].exp, $sformatf("vec%0d", k), (k % 2) == 1);
            wait_done($sformatf("vec%0d", k), (k % 2) == 1);
        end

        // Accumulate with the first result held under backpressure.
        i_rdy = 1'b0;
        send(op_t'(3), op_t'(5), 1'b0, res_t'(15), "bp_first", 1'b0);
        n = 0;
        while (!o_vld && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_hold_vld%0d", k), res_t'(o_vld), res_t'(1));
            chk($sformatf("bp_hold_res%0d", k), o_res, res_t'(15));
            @(posedge i_clk);
            #1;
        end
        i_rdy = 1'b1;
        wait_done("bp_first", 1'b0);
        send(op_t'(7), op_t'(11), 1'b1, res_t'(92), "bp_acc", 1'b0);
        wait_done("bp_acc", 1'b0);

        // Reset in the middle of a transaction discards it.
        send(op_t'(100), op_t'(200), 1'b0, res_t'(20000), "mid_rst", 1'b0);
        repeat (10) begin
            @(posedge i_clk);
            #1;
        end
        i_rstn = 1'b0;
        sb.delete();
        #1;
        chk_idle_reset("mid_rst_during");
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        chk_idle_reset("mid_rst_hold");
        i_rstn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            if (o_vld) seen++;
        end
        chk("mid_rst_no_vld", res_t'(seen), res_t'(0));
        a1 = rnd_op();
        b1 = rnd_op();
        send(a1, b1, 1'b0, model_mul(a1, b1), "after_rst", 1'b0);
        wait_done("after_rst", 1'b0);

        // Request held with changing operands while busy must not disturb the result.
        a1 = rnd_op();
        b1 = rnd_op();
        send(a1, b1, 1'b0, model_mul(a1, b1), "ignored_req", 1'b0);
        i_vld = 1'b1;
        repeat (10) begin
            i_a   = rnd_op();
            i_b   = rnd_op();
            i_acc = 1'b1;
            @(posedge i_clk);
            #1;
        end
        i_vld = 1'b0;
        wait_done("ignored_req", 1'b0);

        // Random operands with random result backpressure; stop at the first miss.
        bad_before = bad;
        for (int r = 0; r < NRND; r++) begin
            a1 = rnd_op();
            b1 = rnd_op();
            send(a1, b1, 1'b0, model_mul(a1, b1), "rnd", 1'b1);
            wait_done("rnd", 1'b1);
            if (bad != bad_before) begin
                $display("random phase stopped at iteration %0d", r);
                break;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
